// File: rtl/simd_alu_sequencer.sv
// -----------------------------------------------------------------------------
// simd_alu_sequencer
//
// Column sequencer for the shared 4-lane SIMD ALU. It applies MixColumns
// (optional) and AddRoundKey to a 128-bit AES state, one 32-bit column per ALU
// operation. Each ALU result is written back verbatim into a working register.
// When column 3 has been keyed, the finished state is presented on state_out
// together with a one-cycle done pulse.
//
// Ports:
//   clk         in   1   clock, all state on the rising edge
//   rst         in   1   asynchronous, active-high reset
//   start       in   1   request, sampled only while idle
//   mix_en      in   1   1 = MixColumns + AddRoundKey, 0 = AddRoundKey only
//   state_in    in 128   input state, column c = state_in[127-32c -: 32]
//   rkey_in     in 128   round key, same column mapping
//   alu_a       out 32   ALU operand A
//   alu_b       out 32   ALU operand B
//   alu_sel     out  3   ALU select (SEL_IDLE / SEL_MIX / SEL_XOR)
//   alu_result  in  32   combinational ALU result, same cycle
//   busy        out  1   high while columns are being processed
//   done        out  1   one-cycle pulse, state_out valid
//   perf_cycles out 16   busy-cycle counter (only with SIMD_SEQ_PERF_EN)
//   state_out   out 128  finished state, held until the next done or reset
//
// Build option: define SIMD_SEQ_PERF_EN to add the saturating perf_cycles
// counter. Without it the port and counter do not exist.
// -----------------------------------------------------------------------------
module simd_alu_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mix_en,
  input  logic [127:0] state_in,
  input  logic [127:0] rkey_in,
  output logic [31:0]  alu_a,
  output logic [31:0]  alu_b,
  output logic [2:0]   alu_sel,
  input  logic [31:0]  alu_result,
  output logic         busy,
  output logic         done,
`ifdef SIMD_SEQ_PERF_EN
  output logic [15:0]  perf_cycles,
`endif
  output logic [127:0] state_out
);

  localparam logic [2:0] SEL_MIX  = 3'b101;
  localparam logic [2:0] SEL_XOR  = 3'b010;
  localparam logic [2:0] SEL_IDLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_ARK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [1:0]     col_r;
  logic [1:0]     col_nxt_s;
  logic [127:0]   work_r;
  logic [127:0]   work_nxt_s;
  logic [127:0]   key_r;
  logic [127:0]   key_nxt_s;
  logic           mix_en_r;
  logic           mix_en_nxt_s;
  logic [127:0]   state_out_nxt_s;
  logic [31:0]    work_col_s;
  logic [31:0]    key_col_s;

  // Column c occupies bits [127-32c -: 32]; column 0 is the most significant.
  function automatic logic [31:0] get_col(input logic [127:0] w, input logic [1:0] c);
    logic [31:0] r;
    case (c)
      2'd0:    r = w[127:96];
      2'd1:    r = w[95:64];
      2'd2:    r = w[63:32];
      2'd3:    r = w[31:0];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Replace one column of a 128-bit state, leaving the other three untouched.
  function automatic logic [127:0] set_col(input logic [127:0] w, input logic [1:0] c,
                                           input logic [31:0] v);
    logic [127:0] r;
    r = w;
    case (c)
      2'd0:    r[127:96] = v;
      2'd1:    r[95:64]  = v;
      2'd2:    r[63:32]  = v;
      2'd3:    r[31:0]   = v;
      default: r = w;
    endcase
    return r;
  endfunction

  assign work_col_s = get_col(work_r, col_r);
  assign key_col_s  = get_col(key_r, col_r);

  // Next-state, datapath update and ALU operand decode from the registered state.
  always_comb begin
    state_nxt_s     = state_r;
    col_nxt_s       = col_r;
    work_nxt_s      = work_r;
    key_nxt_s       = key_r;
    mix_en_nxt_s    = mix_en_r;
    state_out_nxt_s = state_out;
    alu_a           = 32'd0;
    alu_b           = 32'd0;
    alu_sel         = SEL_IDLE;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          work_nxt_s   = state_in;
          key_nxt_s    = rkey_in;
          col_nxt_s    = 2'd0;
          mix_en_nxt_s = mix_en;
          state_nxt_s  = mix_en ? ST_MIX : ST_ARK;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end

      ST_MIX: begin
        alu_a       = work_col_s;
        alu_b       = 32'd0;
        alu_sel     = SEL_MIX;
        work_nxt_s  = set_col(work_r, col_r, alu_result);
        state_nxt_s = ST_ARK;
      end

      ST_ARK: begin
        alu_a      = work_col_s;
        alu_b      = key_col_s;
        alu_sel    = SEL_XOR;
        work_nxt_s = set_col(work_r, col_r, alu_result);
        if (col_r == 2'd3) begin
          // Load the result on the edge into DONE so it is visible while done is high.
          state_out_nxt_s = work_nxt_s;
          state_nxt_s     = ST_DONE;
        end else begin
          col_nxt_s   = col_r + 2'd1;
          state_nxt_s = mix_en_r ? ST_MIX : ST_ARK;
        end
      end

      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      col_r     <= 2'd0;
      work_r    <= 128'd0;
      key_r     <= 128'd0;
      mix_en_r  <= 1'b0;
      state_out <= 128'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      col_r     <= col_nxt_s;
      work_r    <= work_nxt_s;
      key_r     <= key_nxt_s;
      mix_en_r  <= mix_en_nxt_s;
      state_out <= state_out_nxt_s;
      // Status flags are registered copies of the next state decode.
      busy      <= (state_nxt_s == ST_MIX) || (state_nxt_s == ST_ARK);
      done      <= (state_nxt_s == ST_DONE);
    end
  end

`ifdef SIMD_SEQ_PERF_EN
  // Saturating count of busy cycles; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= 16'd0;
    end else if (busy && (perf_cycles != 16'hFFFF)) begin
      perf_cycles <= perf_cycles + 16'd1;
    end else begin
      perf_cycles <= perf_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_simd_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_simd_alu_sequencer
//
// Self-checking bench for simd_alu_sequencer. A behavioural SIMD ALU (GF(2^8)
// MixColumns and lane XOR) answers the sequencer's operand requests. Expected
// finished states are queued when a run is started and compared at done.
// -----------------------------------------------------------------------------
module tb_simd_alu_sequencer;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mix_en;
  logic [127:0] state_in;
  logic [127:0] rkey_in;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [2:0]   alu_sel;
  logic [31:0]  alu_result;
  logic         busy;
  logic         done;
  logic [127:0] state_out;
`ifdef SIMD_SEQ_PERF_EN
  logic [15:0]  perf_cycles;
`endif

  int checks;
  int errors;
  logic [127:0] exp_q[$];

  simd_alu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mix_en     (mix_en),
    .state_in   (state_in),
    .rkey_in    (rkey_in),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done),
`ifdef SIMD_SEQ_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic m);
    logic [127:0] r;
    logic [31:0]  c;
    for (int i = 0; i < 4; i++) begin
      c = s[127-32*i -: 32];
      if (m) c = mixcol(c);
      c = c ^ k[127-32*i -: 32];
      r[127-32*i -: 32] = c;
    end
    return r;
  endfunction

  // Behavioural model of the shared SIMD ALU.
  always_comb begin
    case (alu_sel)
      3'b101:  alu_result = mixcol(alu_a);
      3'b010:  alu_result = alu_a ^ alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  // One complete run: start, watch the busy window, compare at done.
  task automatic run_op(input logic [127:0] s, input logic [127:0] k, input logic m,
                        input logic [127:0] exp, input int exp_done, input bit poke,
                        input int tail, input string nm);
    int cyc, busy_n, extra;
    bit seen;
    logic [23:0] seq, exp_seq;
    logic [127:0] want;
    exp_q.push_back(exp);
    exp_seq = 24'd0;
    for (int i = 0; i < 4; i++) begin
      if (m) exp_seq = {exp_seq[17:0], 3'b101, 3'b010};
      else   exp_seq = {exp_seq[20:0], 3'b010};
    end
    seq = 24'd0; busy_n = 0; cyc = 0; seen = 1'b0; extra = 0;
    @(negedge clk);
    state_in = s; rkey_in = k; mix_en = m; start = 1'b1;
    @(posedge clk);
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) begin
        busy_n++;
        seq = {seq[20:0], alu_sel};
      end
      if (done) begin
        seen = 1'b1;
        checks++;
        if (cyc !== exp_done) begin
          errors++; $display("FAIL %s done_cycle got %0d want %0d", nm, cyc, exp_done);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s scoreboard empty", nm);
        end else begin
          want = exp_q.pop_front();
          if (state_out !== want) begin
            errors++; $display("FAIL %s state_out got %h want %h", nm, state_out, want);
          end
        end
        checks++;
        if (alu_sel !== 3'b000 || busy !== 1'b0) begin
          errors++; $display("FAIL %s done_idle sel %b busy %b want 000 0", nm, alu_sel, busy);
        end
      end
      // Disturb inputs after acceptance; they must have no effect.
      start = (poke && cyc == 3) ? 1'b1 : 1'b0;
      state_in = {$urandom, $urandom, $urandom, $urandom};
      rkey_in  = {$urandom, $urandom, $urandom, $urandom};
      mix_en   = ~m;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout no done within 20 cycles", nm);
      void'(exp_q.pop_front());
    end
    checks++;
    if (busy_n !== exp_done - 1) begin
      errors++; $display("FAIL %s busy_cycles got %0d want %0d", nm, busy_n, exp_done - 1);
    end
    checks++;
    if (seq !== exp_seq) begin
      errors++; $display("FAIL %s sel_seq got %h want %h", nm, seq, exp_seq);
    end
    if (tail > 0) begin
      for (int t = 0; t < tail; t++) begin
        @(negedge clk);
        if (busy || done) extra++;
      end
      checks++;
      if (extra !== 0) begin
        errors++; $display("FAIL %s restart activity got %0d want 0", nm, extra);
      end
    end
  endtask

  task automatic test_reset;
    start = 1'b0; mix_en = 1'b0; state_in = 128'd0; rkey_in = 128'd0; rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset busy/done got %b%b want 00", busy, done);
    end
    checks++;
    if (state_out !== 128'd0) begin
      errors++; $display("FAIL reset state_out got %h want 0", state_out);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_sel !== 3'b000) begin
      errors++; $display("FAIL reset alu got %h %h %b want 0 0 000", alu_a, alu_b, alu_sel);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ark_only;
    run_op(128'd0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
           128'h000102030405060708090a0b0c0d0e0f, 5, 1'b0, 2, "ark_only");
  endtask

  task automatic test_full_round;
    run_op({16{8'h01}}, {16{8'hff}}, 1'b1, {16{8'hfe}}, 9, 1'b0, 2, "full_round");
  endtask

  task automatic test_random;
    logic [127:0] s, k;
    logic m;
    for (int i = 0; i < 4; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      m = (i % 2 == 0);
      run_op(s, k, m, ref_round(s, k, m), m ? 9 : 5, 1'b0, 1, "random");
    end
  endtask

  task automatic test_ignored_start;
    logic [127:0] s, k;
    s = 128'h00112233445566778899aabbccddeeff;
    k = 128'h0f0e0d0c0b0a09080706050403020100;
    run_op(s, k, 1'b1, ref_round(s, k, 1'b1), 9, 1'b1, 4, "ignored_start");
  endtask

  task automatic test_back_to_back;
    logic [127:0] s, k;
    s = 128'hdb135345f20a225c01010101c6c6c6c6;
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_op(s, k, 1'b1, ref_round(s, k, 1'b1), 9, 1'b0, 0, "b2b_first");
    run_op(k, s, 1'b0, ref_round(k, s, 1'b0), 5, 1'b0, 1, "b2b_second");
  endtask

  task automatic test_reset_mid;
    int dn;
    logic [127:0] s, k;
    dn = 0;
    @(negedge clk);
    state_in = {$urandom, $urandom, $urandom, $urandom};
    rkey_in  = {$urandom, $urandom, $urandom, $urandom};
    mix_en = 1'b1; start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_sel !== 3'b000) begin
      errors++; $display("FAIL reset_mid outputs busy %b done %b sel %b want 0 0 000",
                         busy, done, alu_sel);
    end
    checks++;
    if (state_out !== 128'd0) begin
      errors++; $display("FAIL reset_mid state_out got %h want 0", state_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++; $display("FAIL reset_mid done_pulses got %0d want 0", dn);
    end
    s = 128'h3243f6a8885a308d313198a2e0370734;
    k = 128'ha0fafe1788542cb123a339392a6c7605;
    run_op(s, k, 1'b1, ref_round(s, k, 1'b1), 9, 1'b0, 1, "after_reset");
  endtask

`ifdef SIMD_SEQ_PERF_EN
  task automatic test_perf;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op({16{8'h01}}, {16{8'hff}}, 1'b1, {16{8'hfe}}, 9, 1'b0, 1, "perf_mix");
    run_op(128'd0, {16{8'h5a}}, 1'b0, {16{8'h5a}}, 5, 1'b0, 1, "perf_ark");
    checks++;
    if (perf_cycles !== 16'd12) begin
      errors++; $display("FAIL perf_cycles got %0d want 12", perf_cycles);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ark_only();
    test_full_round();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SIMD_SEQ_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_alu_sequencer.md
# simd_alu_sequencer

Column sequencer that drives the shared 4-lane SIMD ALU (four 8-bit lanes plus the GF(2^8) MixColumns path) to apply MixColumns and AddRoundKey to a full 128-bit AES state. It walks the four 32-bit columns and issues one ALU operation per cycle, writing each lane result back into an internal working register. It raises `done` with the finished state. It sits between the round control logic and the SIMD ALU instance, and owns that ALU's operand and select inputs while busy.

## Interface
- `SEL_MIX`, 3'b101: ALU select code for the GF MixColumns path.
- `SEL_XOR`, 3'b010: ALU select code for the lane-wise XOR used for AddRoundKey.
- `SEL_IDLE`, 3'b000: select code driven when not sequencing.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `mix_en` in 1: 1 = MixColumns then AddRoundKey; 0 = AddRoundKey only (final round). Sampled with `start`.
- `state_in` in 128: input state; column c = `state_in[127-32c -: 32]`.
- `rkey_in` in 128: round key, same column mapping.
- `alu_a` out 32: ALU operand A.
- `alu_b` out 32: ALU operand B.
- `alu_sel` out 3: ALU select.
- `alu_result` in 32: combinational ALU result, returned in the same cycle.
- `busy` out 1: high in MIX/ARK.
- `done` out 1: one-cycle pulse, result valid.
- `state_out` out 128: finished state, held until next `done` or reset.

## Operation
- States: IDLE, MIX, ARK, DONE. 2-bit column counter `col`, 128-bit working register `work`, 128-bit key register `key`.
- IDLE, `start`=1: `work`<=`state_in`, `key`<=`rkey_in`, `col`<=0, latch `mix_en`. Next state is MIX if `mix_en`=1, else ARK. `start`=0: stay in IDLE.
- MIX:
  - `alu_a`=`work` column `col`, `alu_b`=0, `alu_sel`=`SEL_MIX`.
  - At the edge: `work` column `col` <= `alu_result`. Next state is ARK.
- ARK:
  - `alu_a`=`work` column `col`, `alu_b`=`key` column `col`, `alu_sel`=`SEL_XOR`.
  - At the edge: `work` column `col` <= `alu_result`.
  - If `col`=3, go to DONE. Otherwise `col`++ and go to MIX (latched `mix_en`=1) or ARK.
- DONE: `state_out`<=`work`, `done`=1. Next state is IDLE unconditionally.
- `start` outside IDLE is ignored, not queued. `state_in`, `rkey_in` and `mix_en` changes after acceptance have no effect.
- In IDLE and DONE: `alu_a`=`alu_b`=0, `alu_sel`=`SEL_IDLE`.
- Lanes are never reordered by this block; `alu_result` is stored verbatim.

## Timing
- Reset values: state IDLE, `col`=0, `busy`=0, `done`=0, `state_out`=0, `work`=`key`=0, `alu_a`=`alu_b`=0, `alu_sel`=`SEL_IDLE`.
- The ALU outputs are decoded from registered state. The ALU path is combinational within one cycle.
- Latency, with the `start` sampling edge counted as edge 0:
  - `mix_en`=1: 8 busy cycles; `done` is high in cycle 9.
  - `mix_en`=0: 4 busy cycles; `done` is high in cycle 5.
- Back-to-back operation: the earliest next acceptance is the edge ending the IDLE cycle that follows DONE.
- `state_out` updates on the DONE cycle edge and is visible in the same cycle that `done` is high.
- `rst` mid-operation: immediate return to reset values. The partial result is discarded and `done` is not asserted.

## Configuration
- `SIMD_SEQ_PERF_EN` defined:
  - Adds output `perf_cycles` (16 bits, reset 0).
  - It increments on every cycle with `busy`=1, saturates at 16'hFFFF, and clears only on `rst`.
- `SIMD_SEQ_PERF_EN` undefined: port and counter absent; all other behaviour is identical.

## Test plan
- Reset state: assert `rst` asynchronously mid-cycle. Required: all outputs at their reset values immediately; `alu_sel`=000.
- AddRoundKey only: `state_in`=0, `rkey_in`=128'h000102030405060708090a0b0c0d0e0f, `mix_en`=0. Required:
  - `busy` is high for 4 cycles.
  - `done` is high at cycle 5.
  - `state_out`=128'h000102030405060708090a0b0c0d0e0f.
- Full round, byte-order invariant: `state_in`=128'h01 repeated, `rkey_in`=128'hff repeated, `mix_en`=1. Required:
  - `alu_sel` sequence is 101, 010, repeated 4 times.
  - `done` is high at cycle 9.
  - `state_out`=128'hfe repeated.
- Ignored start: pulse `start` again while `busy`. Required: single `done` pulse, result unchanged, no restart. After DONE followed by one IDLE cycle, a new start is accepted.
- Reset mid-operation: assert `rst` in cycle 4 of a `mix_en`=1 run. Required:
  - no `done` pulse;
  - `state_out`=0;
  - the next start completes normally at cycle 9.
- `SIMD_SEQ_PERF_EN`: two runs, `mix_en`=1 then `mix_en`=0. Required: `perf_cycles`=12.
